// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Operands are latched on accept and held on the ALU for ALU_LAT cycles; result returned via valid/ready.
module alu_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int NUM_OPS = 9
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic [31:0] REQ0_OP1,
   input  logic [31:0] REQ0_OP2,
   input  logic [5:0]  REQ0_OPRN,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic [31:0] REQ1_OP1,
   input  logic [31:0] REQ1_OP2,
   input  logic [5:0]  REQ1_OPRN,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic        RSP_ID,
   output logic [31:0] RSP_DATA,
   output logic        RSP_ZERO,
   output logic        RSP_ERR,
   output logic [31:0] ALU_OP1,
   output logic [31:0] ALU_OP2,
   output logic [5:0]  ALU_OPRN,
   input  logic [31:0] ALU_OUT,
   input  logic        ALU_ZERO,
   output logic        BUSY
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int         CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   logic [1:0]       r_state;
   logic             r_prio;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_op1;
   logic [31:0]      r_op2;
   logic [5:0]       r_oprn;
   logic             r_id;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_zero;
   logic             r_rsp_err;

   logic        w_idle;
   logic        w_exec;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_accept;
   logic [31:0] w_sel_op1;
   logic [31:0] w_sel_op2;
   logic [5:0]  w_sel_oprn;
   logic        w_legal;

   assign w_idle = (r_state == S_IDLE);
   assign w_exec = (r_state == S_EXEC);

   // A lone valid requester always wins; priority only breaks ties. Reset blocks any grant.
   assign w_grant0 = ~RST & w_idle & REQ0_VALID & (~REQ1_VALID | ~r_prio);
   assign w_grant1 = ~RST & w_idle & REQ1_VALID & (~REQ0_VALID |  r_prio);
   assign w_accept = w_grant0 | w_grant1;

   assign w_sel_op1  = w_grant1 ? REQ1_OP1  : REQ0_OP1;
   assign w_sel_op2  = w_grant1 ? REQ1_OP2  : REQ0_OP2;
   assign w_sel_oprn = w_grant1 ? REQ1_OPRN : REQ0_OPRN;
   assign w_legal    = (w_sel_oprn != 6'd0) && (w_sel_oprn <= 6'(NUM_OPS));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_prio     <= 1'b0;
         r_cnt      <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_oprn     <= '0;
         r_id       <= 1'b0;
         r_rsp_data <= '0;
         r_rsp_zero <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op1  <= w_sel_op1;
                  r_op2  <= w_sel_op2;
                  r_oprn <= w_sel_oprn;
                  r_id   <= w_grant1;
                  if (w_legal) begin
                     r_state <= S_EXEC;
                     r_cnt   <= CNT_W'(ALU_LAT - 1);
                  end else begin
                     r_state    <= S_RESP;
                     r_rsp_data <= '0;
                     r_rsp_zero <= 1'b0;
                     r_rsp_err  <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  r_state    <= S_RESP;
                  r_rsp_data <= ALU_OUT;
                  r_rsp_zero <= ALU_ZERO;
                  r_rsp_err  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (RSP_READY) begin
                  r_state <= S_IDLE;
                  r_prio  <= ~r_id;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ0_READY = w_grant0;
   assign REQ1_READY = w_grant1;
   assign RSP_VALID  = (r_state == S_RESP);
   assign RSP_ID     = r_id;
   assign RSP_DATA   = r_rsp_data;
   assign RSP_ZERO   = r_rsp_zero;
   assign RSP_ERR    = r_rsp_err;
   // The ALU only sees live operands while executing; otherwise it gets the no-op code.
   assign ALU_OP1    = w_exec ? r_op1  : '0;
   assign ALU_OP2    = w_exec ? r_op2  : '0;
   assign ALU_OPRN   = w_exec ? r_oprn : '0;
   assign BUSY       = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter (ALU_LAT=1 and ALU_LAT=3 instances)
module tb_alu_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic        zero;
      logic        err;
   } rsp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid [2][2];
   logic        req_ready [2][2];
   logic [31:0] req_op1   [2][2];
   logic [31:0] req_op2   [2][2];
   logic [5:0]  req_oprn  [2][2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic        rsp_id    [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_zero  [2];
   logic        rsp_err   [2];
   logic [31:0] alu_op1   [2];
   logic [31:0] alu_op2   [2];
   logic [5:0]  alu_oprn  [2];
   logic [31:0] alu_out   [2];
   logic        alu_zero  [2];
   logic        busy      [2];

   rsp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   alu_arbiter #(.ALU_LAT(1), .NUM_OPS(9)) u_lat1 (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(req_valid[0][0]), .REQ0_READY(req_ready[0][0]),
      .REQ0_OP1(req_op1[0][0]), .REQ0_OP2(req_op2[0][0]), .REQ0_OPRN(req_oprn[0][0]),
      .REQ1_VALID(req_valid[0][1]), .REQ1_READY(req_ready[0][1]),
      .REQ1_OP1(req_op1[0][1]), .REQ1_OP2(req_op2[0][1]), .REQ1_OPRN(req_oprn[0][1]),
      .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_ID(rsp_id[0]),
      .RSP_DATA(rsp_data[0]), .RSP_ZERO(rsp_zero[0]), .RSP_ERR(rsp_err[0]),
      .ALU_OP1(alu_op1[0]), .ALU_OP2(alu_op2[0]), .ALU_OPRN(alu_oprn[0]),
      .ALU_OUT(alu_out[0]), .ALU_ZERO(alu_zero[0]), .BUSY(busy[0])
   );

   alu_arbiter #(.ALU_LAT(3), .NUM_OPS(9)) u_lat3 (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(req_valid[1][0]), .REQ0_READY(req_ready[1][0]),
      .REQ0_OP1(req_op1[1][0]), .REQ0_OP2(req_op2[1][0]), .REQ0_OPRN(req_oprn[1][0]),
      .REQ1_VALID(req_valid[1][1]), .REQ1_READY(req_ready[1][1]),
      .REQ1_OP1(req_op1[1][1]), .REQ1_OP2(req_op2[1][1]), .REQ1_OPRN(req_oprn[1][1]),
      .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_ID(rsp_id[1]),
      .RSP_DATA(rsp_data[1]), .RSP_ZERO(rsp_zero[1]), .RSP_ERR(rsp_err[1]),
      .ALU_OP1(alu_op1[1]), .ALU_OP2(alu_op2[1]), .ALU_OPRN(alu_oprn[1]),
      .ALU_OUT(alu_out[1]), .ALU_ZERO(alu_zero[1]), .BUSY(busy[1])
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] o);
      case (o)
         6'h1: return a + b;
         6'h2: return a - b;
         6'h3: return a * b;
         6'h4: return a >> b;
         6'h5: return a << b;
         6'h6: return a & b;
         6'h7: return a | b;
         6'h8: return ~(a | b);
         6'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_out[0]  = alu_f(alu_op1[0], alu_op2[0], alu_oprn[0]);
   assign alu_out[1]  = alu_f(alu_op1[1], alu_op2[1], alu_oprn[1]);
   assign alu_zero[0] = (alu_out[0] == 32'd0);
   assign alu_zero[1] = (alu_out[1] == 32'd0);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs(input int k);
      return 64'({busy[k], rsp_valid[k], rsp_id[k], rsp_zero[k], rsp_err[k],
                  req_ready[k][0], req_ready[k][1], |rsp_data[k], |alu_op1[k],
                  |alu_op2[k], |alu_oprn[k]});
   endfunction

   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (rsp_valid[k] && rsp_ready[k]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("unexpected_rsp%0d", k), 64'(rsp_valid[k]), 64'd0);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk($sformatf("rsp%0d_id_data_zero_err", k),
                   64'({rsp_id[k], rsp_data[k], rsp_zero[k], rsp_err[k]}), 64'(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic drive(input int k, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] o);
      req_valid[k][r] = 1'b1;
      req_op1[k][r]   = a;
      req_op2[k][r]   = b;
      req_oprn[k][r]  = o;
   endtask

   task automatic wait_accept(input int k, input int r);
      int n;
      n = 0;
      mid();
      while (!req_ready[k][r] && n < 30) begin
         tick();
         mid();
         n++;
      end
      chk($sformatf("accept_k%0d_r%0d", k, r), 64'(req_ready[k][r]), 64'd1);
      tick();
      req_valid[k][r] = 1'b0;
   endtask

   task automatic issue(input int k, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] o, input rsp_t e);
      drive(k, r, a, b, o);
      exp_q.push_back(e);
      wait_accept(k, r);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rsp_ready[k] = 1'b1;
         for (int r = 0; r < 2; r++) begin
            req_valid[k][r] = 1'b0;
            req_op1[k][r]   = '0;
            req_op2[k][r]   = '0;
            req_oprn[k][r]  = '0;
         end
      end

      // reset: a pending request must not be granted while RST is high
      tick();
      tick();
      drive(0, 0, 32'd1, 32'd1, 6'h1);
      mid();
      chk("rst_blocks_ready", 64'(req_ready[0][0]), 64'd0);
      tick();
      req_valid[0][0] = 1'b0;
      RST = 1'b0;
      mid();
      chk("reset_outs_lat1", outs(0), 64'd0);
      chk("reset_outs_lat3", outs(1), 64'd0);

      // test 1: add 5+7, ALU_LAT=1 latency
      tick();
      drive(0, 0, 32'd5, 32'd7, 6'h1);
      exp_q.push_back('{id: 1'b0, data: 32'd12, zero: 1'b0, err: 1'b0});
      mid();
      chk("t1_ready_c0", 64'(req_ready[0][0]), 64'd1);
      chk("t1_alu_idle_c0", 64'(alu_oprn[0]), 64'd0);
      tick();
      req_valid[0][0] = 1'b0;
      mid();
      chk("t1_alu_oprn_c1", 64'(alu_oprn[0]), 64'h1);
      chk("t1_alu_ops_c1", {alu_op1[0], alu_op2[0]}, {32'd5, 32'd7});
      chk("t1_no_rsp_c1", 64'(rsp_valid[0]), 64'd0);
      tick();
      mid();
      chk("t1_rsp_valid_c2", 64'(rsp_valid[0]), 64'd1);
      tick();

      RST = 1'b1;
      tick();
      RST = 1'b0;

      // test 2: contention, req0 holds priority after reset and gets it back after req1
      drive(0, 0, 32'd9, 32'd9, 6'h2);
      drive(0, 1, 32'hF0, 32'h0F, 6'h7);
      exp_q.push_back('{id: 1'b0, data: 32'd0, zero: 1'b1, err: 1'b0});
      exp_q.push_back('{id: 1'b1, data: 32'hFF, zero: 1'b0, err: 1'b0});
      mid();
      chk("t2_grant_req0", 64'({req_ready[0][0], req_ready[0][1]}), 64'b10);
      tick();
      req_valid[0][0] = 1'b0;
      wait_accept(0, 1);
      drain();
      drive(0, 0, 32'd1, 32'd1, 6'h1);
      drive(0, 1, 32'hF0, 32'h3C, 6'h6);
      exp_q.push_back('{id: 1'b0, data: 32'd2, zero: 1'b0, err: 1'b0});
      exp_q.push_back('{id: 1'b1, data: 32'h30, zero: 1'b0, err: 1'b0});
      mid();
      chk("t2_regrant_req0", 64'({req_ready[0][0], req_ready[0][1]}), 64'b10);
      tick();
      req_valid[0][0] = 1'b0;
      wait_accept(0, 1);
      drain();

      // test 3: illegal opcodes answer next cycle with ERR and never reach the ALU
      drive(0, 1, 32'd3, 32'd4, 6'h0B);
      exp_q.push_back('{id: 1'b1, data: 32'd0, zero: 1'b0, err: 1'b1});
      mid();
      chk("t3_ready", 64'(req_ready[0][1]), 64'd1);
      tick();
      req_valid[0][1] = 1'b0;
      mid();
      chk("t3_rsp_next_cycle", 64'(rsp_valid[0]), 64'd1);
      chk("t3_alu_oprn_zero", 64'(alu_oprn[0]), 64'd0);
      tick();
      issue(0, 0, 32'd1, 32'd2, 6'h0A, '{id: 1'b0, data: 32'd0, zero: 1'b0, err: 1'b1});
      drain();
      issue(0, 0, 32'd1, 32'd2, 6'h00, '{id: 1'b0, data: 32'd0, zero: 1'b0, err: 1'b1});
      drain();

      // test 6: slt both ways, and highest legal code
      issue(0, 0, 32'd3, 32'd8, 6'h9, '{id: 1'b0, data: 32'd1, zero: 1'b0, err: 1'b0});
      drain();
      issue(0, 0, 32'd8, 32'd3, 6'h9, '{id: 1'b0, data: 32'd0, zero: 1'b1, err: 1'b0});
      drain();

      // test 4: ALU_LAT=3 mul with response back-pressure
      rsp_ready[1] = 1'b0;
      drive(1, 1, 32'h10000, 32'h10, 6'h3);
      exp_q.push_back('{id: 1'b1, data: 32'h100000, zero: 1'b0, err: 1'b0});
      mid();
      chk("t4_ready", 64'(req_ready[1][1]), 64'd1);
      tick();
      req_valid[1][1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk($sformatf("t4_exec%0d_oprn", i), 64'(alu_oprn[1]), 64'h3);
         chk($sformatf("t4_exec%0d_ops", i), {alu_op1[1], alu_op2[1]}, {32'h10000, 32'h10});
         chk($sformatf("t4_exec%0d_busy_rspv", i), 64'({busy[1], rsp_valid[1]}), 64'b10);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         mid();
         chk($sformatf("t4_hold%0d_valid_busy", i), 64'({rsp_valid[1], busy[1]}), 64'b11);
         chk($sformatf("t4_hold%0d_data", i), 64'(rsp_data[1]), 64'h100000);
         chk($sformatf("t4_hold%0d_alu_idle", i), 64'(alu_oprn[1]), 64'd0);
         tick();
      end
      rsp_ready[1] = 1'b1;
      mid();
      tick();
      mid();
      chk("t4_idle_after", 64'(busy[1]), 64'd0);
      chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
      tick();

      // test 5: reset in the 2nd EXEC cycle abandons the op
      drive(1, 0, 32'd1, 32'd2, 6'h1);
      mid();
      chk("t5_ready", 64'(req_ready[1][0]), 64'd1);
      tick();
      req_valid[1][0] = 1'b0;
      mid();
      chk("t5_exec1_busy", 64'(busy[1]), 64'd1);
      tick();
      RST = 1'b1;
      mid();
      chk("t5_exec2_oprn", 64'(alu_oprn[1]), 64'h1);
      tick();
      RST = 1'b0;
      mid();
      chk("t5_outs_after_rst", outs(1), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         mid();
         chk($sformatf("t5_no_rsp%0d", i), 64'(rsp_valid[1]), 64'd0);
      end
      tick();

      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
